// File: rtl/sha256_pkg.sv
// Shared SHA-256 constants plus the feeder's state and pad-kind types.
package sha256_pkg;

  localparam int BLOCK_W  = 512;
  localparam int WORD_W   = 32;
  localparam int DIGEST_W = 256;
  localparam int IDX_W    = 7;  // byte index 0..64

  localparam logic [WORD_W-1:0] H0 = 32'h6a09e667;
  localparam logic [WORD_W-1:0] H1 = 32'hbb67ae85;
  localparam logic [WORD_W-1:0] H2 = 32'h3c6ef372;
  localparam logic [WORD_W-1:0] H3 = 32'ha54ff53a;
  localparam logic [WORD_W-1:0] H4 = 32'h510e527f;
  localparam logic [WORD_W-1:0] H5 = 32'h9b05688c;
  localparam logic [WORD_W-1:0] H6 = 32'h1f83d9ab;
  localparam logic [WORD_W-1:0] H7 = 32'h5be0cd19;
  localparam logic [DIGEST_W-1:0] IV = {H0, H1, H2, H3, H4, H5, H6, H7};

  typedef enum logic [2:0] {
    ST_FILL,
    ST_PAD,
    ST_ISSUE,
    ST_WAIT_LO,
    ST_WAIT_HI
  } feeder_state_e;

  typedef enum logic [1:0] {
    PAD2_NONE,
    PAD2_ZERO_HEAD,
    PAD2_80_HEAD
  } pad2_kind_e;

  // Bit position of the least significant bit of big-endian byte idx.
  function automatic logic [8:0] byte_lsb(input logic [5:0] idx);
    return 9'd504 - {idx, 3'b000};
  endfunction

endpackage

// File: rtl/sha256_msg_feeder_if.sv
// Host byte stream, core handshake and digest signals of the feeder.
// Optional abort input is present when SHA256_FEEDER_ABORT_EN is defined.
//
// Byte handshake: a byte moves on a rising edge where in_valid && in_ready;
// the host holds in_data/in_last stable while in_valid=1 and in_ready=0.
interface sha256_msg_feeder_if;
  import sha256_pkg::*;

  logic                in_valid;
  logic                in_ready;
  logic [7:0]          in_data;
  logic                in_last;
  logic                core_start;
  logic                core_first_run;
  logic [BLOCK_W-1:0]  core_block;
  logic                core_ready;
  logic [DIGEST_W-1:0] core_hash;
  logic [DIGEST_W-1:0] digest;
  logic                digest_valid;
  logic                busy;
  feeder_state_e       state;
`ifdef SHA256_FEEDER_ABORT_EN
  logic                abort;

  modport master (
    input  in_valid, in_data, in_last, core_ready, core_hash, abort,
    output in_ready, core_start, core_first_run, core_block,
           digest, digest_valid, busy, state
  );
  modport slave (
    output in_valid, in_data, in_last, core_ready, core_hash, abort,
    input  in_ready, core_start, core_first_run, core_block,
           digest, digest_valid, busy, state
  );
`else
  modport master (
    input  in_valid, in_data, in_last, core_ready, core_hash,
    output in_ready, core_start, core_first_run, core_block,
           digest, digest_valid, busy, state
  );
  modport slave (
    output in_valid, in_data, in_last, core_ready, core_hash,
    input  in_ready, core_start, core_first_run, core_block,
           digest, digest_valid, busy, state
  );
`endif
endinterface

// File: rtl/sha256_pad_gen.sv
// Combinational SHA-256 padding: pads a partial block at byte idx, or builds
// the dedicated second pad block when kind_i names one.
module sha256_pad_gen
  import sha256_pkg::*;
(
  input  logic [BLOCK_W-1:0] block_i,
  input  logic [IDX_W-1:0]   idx_i,
  input  logic [63:0]        len_i,
  input  pad2_kind_e         kind_i,
  output logic [BLOCK_W-1:0] block_o,
  output logic               final_o,
  output pad2_kind_e         pad2_o
);

  always_comb begin
    block_o = block_i;
    final_o = 1'b0;
    pad2_o  = PAD2_NONE;
    if (kind_i == PAD2_NONE) begin
      for (int j = 0; j < 64; j++) begin
        if (j == int'(idx_i)) begin
          block_o[8*(63-j) +: 8] = 8'h80;
        end else if (j > int'(idx_i)) begin
          block_o[8*(63-j) +: 8] = 8'h00;
        end
      end
      // Length fits only if the 0x80 marker landed at or before byte 55.
      if (idx_i <= 7'd55) begin
        block_o[63:0] = len_i;
        final_o       = 1'b1;
      end else if (idx_i <= 7'd63) begin
        pad2_o = PAD2_ZERO_HEAD;
      end else begin
        pad2_o = PAD2_80_HEAD;
      end
    end else begin
      block_o = '0;
      if (kind_i == PAD2_80_HEAD) begin
        block_o[BLOCK_W-1 -: 8] = 8'h80;
      end
      block_o[63:0] = len_i;
      final_o       = 1'b1;
    end
  end

endmodule

// File: rtl/sha256_msg_feeder.sv
// Packs a host byte stream into padded 512-bit blocks and drives the SHA-256
// core block by block. Define SHA256_FEEDER_ABORT_EN to add the abort input.
module sha256_msg_feeder
  import sha256_pkg::*;
#(
  parameter int LEN_W = 64
) (
  input  logic clk,
  input  logic rst_n,
  sha256_msg_feeder_if.master bus
);

  feeder_state_e       state_q, state_d;
  logic [IDX_W-1:0]    idx_q, idx_d;
  logic [LEN_W-1:0]    len_q, len_d;
  logic                first_q, first_d;
  logic                final_q, final_d;
  pad2_kind_e          pad2_q, pad2_d;
  logic [BLOCK_W-1:0]  block_q, block_d;
  logic [DIGEST_W-1:0] digest_q, digest_d;
  logic                digest_valid_q, digest_valid_d;
  logic                busy_q, busy_d;
`ifdef SHA256_FEEDER_ABORT_EN
  logic                discard_q, discard_d;
`endif

  logic               xfer;
  logic [BLOCK_W-1:0] pad_block;
  logic               pad_final;
  pad2_kind_e         pad_pad2;
  pad2_kind_e         pad_kind;

  assign bus.in_ready       = (state_q == ST_FILL);
  assign bus.core_start     = (state_q == ST_ISSUE);
  assign bus.core_first_run = (state_q == ST_ISSUE) && first_q;
  assign bus.core_block     = block_q;
  assign bus.digest         = digest_q;
  assign bus.digest_valid   = digest_valid_q;
  assign bus.busy           = busy_q;
  assign bus.state          = state_q;

  assign xfer     = bus.in_valid && (state_q == ST_FILL);
  assign pad_kind = (state_q == ST_WAIT_HI) ? pad2_q : PAD2_NONE;

  sha256_pad_gen u_pad_gen (
    .block_i (block_q),
    .idx_i   (idx_q),
    .len_i   (64'(len_q)),
    .kind_i  (pad_kind),
    .block_o (pad_block),
    .final_o (pad_final),
    .pad2_o  (pad_pad2)
  );

  always_comb begin
    state_d        = state_q;
    idx_d          = idx_q;
    len_d          = len_q;
    first_d        = first_q;
    final_d        = final_q;
    pad2_d         = pad2_q;
    block_d        = block_q;
    digest_d       = digest_q;
    digest_valid_d = 1'b0;
    busy_d         = busy_q;
`ifdef SHA256_FEEDER_ABORT_EN
    discard_d      = discard_q;
`endif
    unique case (state_q)
      ST_FILL: begin
        if (xfer) begin
          block_d[byte_lsb(idx_q[5:0]) +: 8] = bus.in_data;
          idx_d  = idx_q + 7'd1;
          len_d  = len_q + LEN_W'(8);
          busy_d = 1'b1;
          if (bus.in_last) begin
            state_d = ST_PAD;
          end else if (idx_q == 7'd63) begin
            state_d = ST_ISSUE;
            final_d = 1'b0;
          end
        end
      end
      ST_PAD: begin
        block_d = pad_block;
        final_d = pad_final;
        pad2_d  = pad_pad2;
        state_d = ST_ISSUE;
      end
      ST_ISSUE: begin
        first_d = 1'b0;
        state_d = ST_WAIT_LO;
      end
      ST_WAIT_LO: begin
        // core_ready may still be high from the previous block.
        if (!bus.core_ready) state_d = ST_WAIT_HI;
      end
      ST_WAIT_HI: begin
        if (bus.core_ready) begin
          if (final_q) begin
            digest_d       = bus.core_hash;
            digest_valid_d = 1'b1;
            first_d        = 1'b1;
            len_d          = '0;
            idx_d          = '0;
            busy_d         = 1'b0;
            block_d        = '0;
            pad2_d         = PAD2_NONE;
            state_d        = ST_FILL;
          end else if (pad2_q != PAD2_NONE) begin
            block_d = pad_block;
            final_d = 1'b1;
            pad2_d  = PAD2_NONE;
            state_d = ST_ISSUE;
          end else begin
            idx_d   = '0;
            block_d = '0;
            state_d = ST_FILL;
          end
`ifdef SHA256_FEEDER_ABORT_EN
          if (discard_q) begin
            digest_d       = digest_q;
            digest_valid_d = 1'b0;
            first_d        = 1'b1;
            len_d          = '0;
            idx_d          = '0;
            busy_d         = 1'b0;
            block_d        = '0;
            pad2_d         = PAD2_NONE;
            discard_d      = 1'b0;
            state_d        = ST_FILL;
          end
`endif
        end
      end
      default: state_d = ST_FILL;
    endcase
`ifdef SHA256_FEEDER_ABORT_EN
    if (bus.abort) begin
      if (state_q == ST_FILL || state_q == ST_PAD) begin
        state_d = ST_FILL;
        idx_d   = '0;
        len_d   = '0;
        first_d = 1'b1;
        busy_d  = 1'b0;
        block_d = '0;
        pad2_d  = PAD2_NONE;
      end else begin
        discard_d = 1'b1;
      end
    end
`endif
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q        <= ST_FILL;
      idx_q          <= '0;
      len_q          <= '0;
      first_q        <= 1'b1;
      final_q        <= 1'b0;
      pad2_q         <= PAD2_NONE;
      block_q        <= '0;
      digest_q       <= '0;
      digest_valid_q <= 1'b0;
      busy_q         <= 1'b0;
`ifdef SHA256_FEEDER_ABORT_EN
      discard_q      <= 1'b0;
`endif
    end else begin
      state_q        <= state_d;
      idx_q          <= idx_d;
      len_q          <= len_d;
      first_q        <= first_d;
      final_q        <= final_d;
      pad2_q         <= pad2_d;
      block_q        <= block_d;
      digest_q       <= digest_d;
      digest_valid_q <= digest_valid_d;
      busy_q         <= busy_d;
`ifdef SHA256_FEEDER_ABORT_EN
      discard_q      <= discard_d;
`endif
    end
  end

endmodule

// File: tb/tb_sha256_msg_feeder.sv
// Bench for sha256_msg_feeder: host byte driver, behavioural SHA-256 core,
// block/digest scoreboard and a final report.
module tb_sha256_msg_feeder;
  import sha256_pkg::*;

  logic clk;
  logic rst_n;
  int   checks   = 0;
  int   failures = 0;
  int   stale_cfg = 0;

  logic [512:0] blk_q[$];   // {first_run, block}
  logic [255:0] dig_q[$];
  logic [7:0]   msg_q[$];

  sha256_msg_feeder_if bus();

  sha256_msg_feeder dut (
    .clk   (clk),
    .rst_n (rst_n),
    .bus   (bus)
  );

  // ---------------- clock / reset ----------------
  initial clk = 1'b0;
  always #5 clk = ~clk;

  initial begin
    #500000;
    $display("FAIL watchdog expired");
    failures++;
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $fatal(1, "watchdog");
  end

  // ---------------- SHA-256 reference ----------------
  localparam logic [31:0] K [64] = '{
    32'h428a2f98, 32'h71374491, 32'hb5c0fbcf, 32'he9b5dba5, 32'h3956c25b, 32'h59f111f1, 32'h923f82a4, 32'hab1c5ed5,
    32'hd807aa98, 32'h12835b01, 32'h243185be, 32'h550c7dc3, 32'h72be5d74, 32'h80deb1fe, 32'h9bdc06a7, 32'hc19bf174,
    32'he49b69c1, 32'hefbe4786, 32'h0fc19dc6, 32'h240ca1cc, 32'h2de92c6f, 32'h4a7484aa, 32'h5cb0a9dc, 32'h76f988da,
    32'h983e5152, 32'ha831c66d, 32'hb00327c8, 32'hbf597fc7, 32'hc6e00bf3, 32'hd5a79147, 32'h06ca6351, 32'h14292967,
    32'h27b70a85, 32'h2e1b2138, 32'h4d2c6dfc, 32'h53380d13, 32'h650a7354, 32'h766a0abb, 32'h81c2c92e, 32'h92722c85,
    32'ha2bfe8a1, 32'ha81a664b, 32'hc24b8b70, 32'hc76c51a3, 32'hd192e819, 32'hd6990624, 32'hf40e3585, 32'h106aa070,
    32'h19a4c116, 32'h1e376c08, 32'h2748774c, 32'h34b0bcb5, 32'h391c0cb3, 32'h4ed8aa4a, 32'h5b9cca4f, 32'h682e6ff3,
    32'h748f82ee, 32'h78a5636f, 32'h84c87814, 32'h8cc70208, 32'h90befffa, 32'ha4506ceb, 32'hbef9a3f7, 32'hc67178f2
  };

  function automatic logic [31:0] rotr(input logic [31:0] x, input int n);
    return (x >> n) | (x << (32 - n));
  endfunction

  function automatic logic [255:0] sha_compress(input logic [255:0] hin, input logic [511:0] blk);
    logic [31:0] w [64];
    logic [31:0] a, b, c, d, e, f, g, h, t1, t2;
    for (int i = 0; i < 16; i++) w[i] = blk[511-32*i -: 32];
    for (int i = 16; i < 64; i++)
      w[i] = w[i-16] + (rotr(w[i-15], 7) ^ rotr(w[i-15], 18) ^ (w[i-15] >> 3))
           + w[i-7] + (rotr(w[i-2], 17) ^ rotr(w[i-2], 19) ^ (w[i-2] >> 10));
    {a, b, c, d, e, f, g, h} = hin;
    for (int i = 0; i < 64; i++) begin
      t1 = h + (rotr(e, 6) ^ rotr(e, 11) ^ rotr(e, 25)) + ((e & f) ^ (~e & g)) + K[i] + w[i];
      t2 = (rotr(a, 2) ^ rotr(a, 13) ^ rotr(a, 22)) + ((a & b) ^ (a & c) ^ (b & c));
      h = g; g = f; f = e; e = d + t1; d = c; c = b; b = a; a = t1 + t2;
    end
    return {hin[255:224] + a, hin[223:192] + b, hin[191:160] + c, hin[159:128] + d,
            hin[127:96] + e, hin[95:64] + f, hin[63:32] + g, hin[31:0] + h};
  endfunction

  // ---------------- behavioural core ----------------
  logic         cm_ready, cm_fr, cm_run, cm_fin;
  logic [255:0] cm_hash;
  logic [511:0] cm_blk;
  int           cm_stale, cm_work;

  assign bus.core_ready = cm_ready;
  assign bus.core_hash  = cm_hash;

  always @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      cm_ready <= 1'b1; cm_hash <= '0; cm_blk <= '0; cm_fr <= 1'b0;
      cm_stale <= 0; cm_work <= 0; cm_run <= 1'b0; cm_fin <= 1'b0;
    end else begin
      cm_fin <= 1'b0;
      if (bus.core_start) begin
        cm_blk <= bus.core_block; cm_fr <= bus.core_first_run;
        cm_stale <= stale_cfg; cm_work <= 3; cm_run <= 1'b1;
        if (stale_cfg == 0) cm_ready <= 1'b0;
      end else if (cm_run) begin
        if (cm_stale != 0) begin
          cm_stale <= cm_stale - 1;
          if (cm_stale == 1) cm_ready <= 1'b0;
        end else if (cm_work != 0) begin
          cm_work <= cm_work - 1;
        end else begin
          cm_hash <= sha_compress(cm_fr ? IV : cm_hash, cm_blk);
          cm_ready <= 1'b1; cm_run <= 1'b0; cm_fin <= 1'b1;
        end
      end
    end
  end

  // ---------------- scoreboard ----------------
  task automatic check(input string name, input logic [511:0] act, input logic [511:0] exp);
    checks++;
    if (act !== exp) begin
      failures++;
      $display("FAIL %s actual=%0h required=%0h", name, act, exp);
    end
  endtask

  always @(negedge clk) begin
    if (rst_n) begin
      if (bus.core_start) begin
        if (blk_q.size() == 0) begin
          checks++; failures++;
          $display("FAIL unexpected_core_start actual=1 required=0");
        end else begin
          logic [512:0] e;
          e = blk_q.pop_front();
          check("core_first_run", 512'(bus.core_first_run), 512'(e[512]));
          check("core_block", bus.core_block, e[511:0]);
        end
      end
      if (cm_fin) check("block_stable", bus.core_block, cm_blk);
      if (bus.digest_valid) begin
        if (dig_q.size() == 0) begin
          checks++; failures++;
          $display("FAIL unexpected_digest_valid actual=1 required=0");
        end else begin
          logic [255:0] d;
          d = dig_q.pop_front();
          check("digest", 512'(bus.digest), 512'(d));
        end
      end
    end
  end

  // Software padding of msg_q; pushes expected blocks and optionally a digest.
  task automatic expect_msg(input bit known_en, input logic [255:0] known, input bit want_digest);
    logic [7:0]   p[$];
    logic [63:0]  bits;
    logic [511:0] blk;
    logic [255:0] h;
    p = msg_q;
    bits = 64'(msg_q.size()) * 64'd8;
    p.push_back(8'h80);
    while (p.size() % 64 != 56) p.push_back(8'h00);
    for (int i = 7; i >= 0; i--) p.push_back(bits[8*i +: 8]);
    h = IV;
    for (int b = 0; b < p.size() / 64; b++) begin
      for (int j = 0; j < 64; j++) blk[511-8*j -: 8] = p[64*b + j];
      blk_q.push_back({(b == 0), blk});
      h = sha_compress(h, blk);
    end
    if (want_digest) dig_q.push_back(known_en ? known : h);
  endtask

  // ---------------- driver ----------------
  task automatic send_byte(input logic [7:0] b, input logic last);
    int n = 0;
    bus.in_valid = 1'b1; bus.in_data = b; bus.in_last = last;
    while (!bus.in_ready && n < 3000) begin
      @(negedge clk); n++;
    end
    if (n >= 3000) begin
      checks++; failures++;
      $display("FAIL in_ready_timeout actual=0 required=1");
    end
    @(negedge clk);
    bus.in_valid = 1'b0; bus.in_last = 1'b0;
  endtask

  task automatic send_msg(input int gap_max);
    for (int i = 0; i < msg_q.size(); i++) begin
      repeat ($urandom_range(0, gap_max)) @(negedge clk);
      send_byte(msg_q[i], i == msg_q.size() - 1);
    end
  endtask

  task automatic wait_idle();
    int n = 0;
    while ((blk_q.size() != 0 || dig_q.size() != 0 || bus.state != ST_FILL || bus.busy) && n < 5000) begin
      @(negedge clk); n++;
    end
    checks++;
    if (n >= 5000) begin
      failures++;
      $display("FAIL idle_timeout actual=%0d required=<5000", n);
    end
  endtask

  task automatic load_str(input string s);
    msg_q.delete();
    for (int i = 0; i < s.len(); i++) msg_q.push_back(s[i]);
  endtask

  task automatic load_pat(input int len, input logic [7:0] base, input bit zero);
    msg_q.delete();
    for (int i = 0; i < len; i++) msg_q.push_back(zero ? 8'h00 : 8'(base + 8'(i % 26)));
  endtask

  task automatic check_reset_outputs(input string tag);
    check({tag, "_in_ready"}, 512'(bus.in_ready), 512'(1'b1));
    check({tag, "_core_start"}, 512'(bus.core_start), 512'(1'b0));
    check({tag, "_core_first_run"}, 512'(bus.core_first_run), 512'(1'b0));
    check({tag, "_core_block"}, bus.core_block, '0);
    check({tag, "_digest"}, 512'(bus.digest), '0);
    check({tag, "_digest_valid"}, 512'(bus.digest_valid), 512'(1'b0));
    check({tag, "_busy"}, 512'(bus.busy), 512'(1'b0));
  endtask

  // ---------------- stimulus ----------------
  localparam logic [255:0] ABC_DIG = 256'hba7816bf8f01cfea414140de5dae2223b00361a396177a9cb410ff61f20015ad;
  localparam logic [255:0] L56_DIG = 256'h248d6a61d20638b8e5c026930c3e6039a33ce45964ff2167f6ecedd419db06c1;
  localparam string        L56_STR = "abcdbcdecdefdefgefghfghighijhijkijkljklmklmnlmnomnopnopq";

  initial begin
    int n;
    rst_n = 1'b0;
    bus.in_valid = 1'b0; bus.in_data = 8'h00; bus.in_last = 1'b0;
`ifdef SHA256_FEEDER_ABORT_EN
    bus.abort = 1'b0;
`endif
    repeat (3) @(negedge clk);
    rst_n = 1'b1;
    @(negedge clk);
    check_reset_outputs("reset");

    // "abc": single block, known digest
    stale_cfg = 0;
    load_str("abc"); expect_msg(1'b1, ABC_DIG, 1'b1); send_msg(0); wait_idle();

    // 56 bytes: pad marker fills block 0, length-only second block
    stale_cfg = 1;
    load_str(L56_STR); expect_msg(1'b1, L56_DIG, 1'b1); send_msg(0); wait_idle();

    // 64 zero bytes: second block starts with 0x80
    stale_cfg = 0;
    load_pat(64, 8'h00, 1'b1); expect_msg(1'b0, '0, 1'b1); send_msg(1); wait_idle();

    // 55 and 119 bytes: length fits in the last data block
    load_pat(55, 8'h61, 1'b0); expect_msg(1'b0, '0, 1'b1); send_msg(0); wait_idle();
    stale_cfg = 1;
    load_pat(119, 8'h41, 1'b0); expect_msg(1'b0, '0, 1'b1); send_msg(3); wait_idle();

    // back-to-back messages with random gaps; second waits in FILL
    load_str("abc"); expect_msg(1'b1, ABC_DIG, 1'b1); send_msg(2);
    load_str(L56_STR); expect_msg(1'b1, L56_DIG, 1'b1); send_msg(2);
    wait_idle();

    // reset while waiting for the core to drop its stale ready
    load_str("abc"); expect_msg(1'b0, '0, 1'b0); send_msg(0);
    n = 0;
    while (bus.state != ST_WAIT_LO && n < 200) begin
      @(negedge clk); n++;
    end
    check("reach_wait_lo", 512'(bus.state == ST_WAIT_LO), 512'(1'b1));
    #2 rst_n = 1'b0;
    @(negedge clk);
    check_reset_outputs("midreset");
    rst_n = 1'b1;
    @(negedge clk);
    stale_cfg = 1;
    load_str("abc"); expect_msg(1'b1, ABC_DIG, 1'b1); send_msg(1); wait_idle();

    repeat (4) @(negedge clk);
    check("blk_q_empty", 512'(blk_q.size()), '0);
    check("dig_q_empty", 512'(dig_q.size()), '0);
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
